// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port memory.
// Round-robin between ports, registered memory interface, fetch kill support.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dc_req,
  input  logic                dc_we,
  input  logic [ADDR_W-1:0]   dc_addr,
  input  logic [DATA_W-1:0]   dc_wdata,
  input  logic [DATA_W/8-1:0] dc_be,
  output logic                dc_valid,
  output logic [DATA_W-1:0]   dc_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    DC_BUSY
  } state_e;

  state_e              state_q, state_d;
  logic                kill_q, kill_d;
  logic                last_if_q, last_if_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic                if_valid_q, if_valid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                dc_valid_q, dc_valid_d;
  logic [DATA_W-1:0]   dc_rdata_q, dc_rdata_d;
  logic                if_elig;
  logic                grant_dc;

  assign if_elig  = if_req & ~if_kill;
  // Data wins when fetch is not eligible, or when fetch was granted last.
  assign grant_dc = dc_req & (~if_elig | last_if_q);

  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    last_if_d   = last_if_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dc_valid_d  = 1'b0;
    dc_rdata_d  = dc_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_dc) begin
          state_d     = DC_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = dc_we;
          mem_addr_d  = dc_addr;
          mem_wdata_d = dc_wdata;
          mem_be_d    = dc_we ? dc_be : '1;
        end else if (if_elig) begin
          state_d     = IF_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
        end
      end
      IF_BUSY: begin
        if (if_kill) kill_d = 1'b1;
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          last_if_d = 1'b1;
          kill_d    = 1'b0;
          // A kill in the completing cycle itself also suppresses delivery.
          if (!kill_q && !if_kill) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      DC_BUSY: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          last_if_d  = 1'b0;
          dc_valid_d = 1'b1;
          dc_rdata_d = mem_we_q ? '0 : mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      last_if_q   <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dc_valid_q  <= 1'b0;
      dc_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      last_if_q   <= last_if_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      dc_valid_q  <= dc_valid_d;
      dc_rdata_q  <= dc_rdata_d;
    end
  end

  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dc_valid  = dc_valid_q;
  assign dc_rdata  = dc_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// all outputs compared every cycle against a transaction-level reference.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_kill;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              dc_req, dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic [BE_W-1:0]   dc_be;
  logic              dc_valid;
  logic [DATA_W-1:0] dc_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_be(dc_be), .dc_valid(dc_valid), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference: one outstanding memory transaction at most, plus a priority bit.
  bit                m_busy, m_is_dc, m_we, m_killed, m_dc_priority;
  logic              e_mem_req, e_mem_we, e_if_valid, e_dc_valid;
  logic [ADDR_W-1:0] e_mem_addr;
  logic [DATA_W-1:0] e_mem_wdata, e_if_rdata, e_dc_rdata;
  logic [BE_W-1:0]   e_mem_be;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_is_dc = 0; m_we = 0; m_killed = 0; m_dc_priority = 1;
    e_mem_req = 0; e_mem_we = 0; e_if_valid = 0; e_dc_valid = 0;
    e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_dc_rdata = '0; e_mem_be = '0;
  endtask

  task automatic model_edge();
    bit want_if;
    e_if_valid = 0;
    e_dc_valid = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      want_if = if_req && !if_kill;
      if (dc_req && (!want_if || m_dc_priority)) begin
        m_busy = 1; m_is_dc = 1; m_we = dc_we; m_killed = 0;
        e_mem_req = 1; e_mem_we = dc_we; e_mem_addr = dc_addr;
        e_mem_wdata = dc_wdata; e_mem_be = dc_we ? dc_be : {BE_W{1'b1}};
      end else if (want_if) begin
        m_busy = 1; m_is_dc = 0; m_we = 0; m_killed = 0;
        e_mem_req = 1; e_mem_we = 0; e_mem_addr = if_addr;
        e_mem_wdata = '0; e_mem_be = {BE_W{1'b1}};
      end
    end else begin
      if (!m_is_dc && if_kill) m_killed = 1;
      if (mem_ack) begin
        e_mem_req = 0;
        e_mem_we  = 0;
        if (m_is_dc) begin
          e_dc_valid = 1;
          e_dc_rdata = m_we ? '0 : mem_rdata;
        end else if (!m_killed) begin
          e_if_valid = 1;
          e_if_rdata = mem_rdata;
        end
        m_dc_priority = !m_is_dc;
        m_busy = 0;
        m_killed = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("mem_req",   mem_req,   e_mem_req);
    check("mem_we",    mem_we,    e_mem_we);
    check("mem_addr",  mem_addr,  e_mem_addr);
    check("mem_wdata", mem_wdata, e_mem_wdata);
    check("mem_be",    mem_be,    e_mem_be);
    check("if_valid",  if_valid,  e_if_valid);
    check("if_rdata",  if_rdata,  e_if_rdata);
    check("dc_valid",  dc_valid,  e_dc_valid);
    check("dc_rdata",  dc_rdata,  e_dc_rdata);
    check("valid_excl", if_valid & dc_valid, 1'b0);
  endtask

  // Inputs change only at negedge; the model sees exactly what the DUT sampled.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 0; if_kill = 0; if_addr = '0;
    dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0; dc_be = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic async_reset_now();
    rst = 0;
    #1;
    model_reset();
    check_outputs();
  endtask

  task automatic do_reset();
    async_reset_now();
    step();
    rst = 1;
  endtask

  int unsigned order_q[$];

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    async_reset_now();
    step();
    rst = 1;
    step();

    // Single fetch with one-cycle memory response.
    if_req = 1; if_addr = 32'h100;
    step();
    check("fetch_addr", mem_addr, 32'h100);
    check("fetch_we", mem_we, 1'b0);
    mem_ack = 1; mem_rdata = 32'h00500093;
    step();
    check("fetch_valid", if_valid, 1'b1);
    check("fetch_rdata", if_rdata, 32'h00500093);
    if_req = 0; mem_ack = 0;
    step();
    check("fetch_pulse", if_valid, 1'b0);

    // Kill during wait: delivery suppressed, old fetch data retained.
    if_req = 1; if_addr = 32'h500;
    step();
    if_kill = 1; if_req = 0;
    step();
    if_kill = 0;
    step();
    mem_ack = 1; mem_rdata = 32'h0000CAFE;
    step();
    check("kill_no_valid", if_valid, 1'b0);
    check("kill_rdata_kept", if_rdata, 32'h00500093);
    mem_ack = 0; if_req = 1; if_addr = 32'h600;
    step();
    check("kill_then_grant", mem_addr, 32'h600);
    mem_ack = 1; mem_rdata = 32'h11112222;
    step();
    check("kill_then_valid", if_valid, 1'b1);
    idle_inputs();
    step();

    // Store with three wait states.
    do_reset();
    dc_req = 1; dc_we = 1; dc_addr = 32'h40; dc_wdata = 32'hDEADBEEF; dc_be = 4'b0011;
    mem_rdata = 32'h55AA55AA;
    step();
    for (int i = 0; i < 4; i++) begin
      check("st_req", mem_req, 1'b1);
      check("st_addr", mem_addr, 32'h40);
      check("st_wdata", mem_wdata, 32'hDEADBEEF);
      check("st_be", mem_be, 4'b0011);
      check("st_we", mem_we, 1'b1);
      mem_ack = (i == 3);
      step();
    end
    check("st_valid", dc_valid, 1'b1);
    check("st_rdata", dc_rdata, 32'h0);
    idle_inputs();
    step();

    // Both ports held from reset with immediate acks: data, fetch, data, fetch.
    if_req = 1; if_addr = 32'h300; dc_req = 1; dc_we = 0; dc_addr = 32'h200;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      mem_ack = mem_req;
      mem_rdata = $urandom;
      step();
      if (dc_valid) order_q.push_back(1);
      if (if_valid) order_q.push_back(0);
    end
    check("rr_count", order_q.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < order_q.size(); i++)
      check("rr_order", order_q[i], (i % 2 == 0) ? 1 : 0);
    idle_inputs();
    step();

    // Reset in the middle of a data access.
    dc_req = 1; dc_we = 0; dc_addr = 32'h80;
    step();
    check("mid_req", mem_req, 1'b1);
    async_reset_now();
    check("mid_req_dropped", mem_req, 1'b0);
    mem_ack = 1;
    step();
    check("mid_no_valid", dc_valid, 1'b0);
    idle_inputs();
    rst = 1;
    if_req = 1; if_addr = 32'h700;
    step();
    check("post_rst_grant", mem_addr, 32'h700);
    mem_ack = 1; mem_rdata = 32'h77;
    step();
    check("post_rst_valid", if_valid, 1'b1);
    idle_inputs();
    step();

    // Spurious ack while idle.
    mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("spur_req", mem_req, 1'b0);
      check("spur_valid", if_valid | dc_valid, 1'b0);
    end
    idle_inputs();
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (!rst) rst = 1;
      if_kill = 0;
      if (if_req) begin
        if (if_valid) begin
          if ($urandom_range(1, 0) == 0) if_req = 0;
        end else if ($urandom_range(19, 0) == 0) begin
          if_kill = 1; if_req = 0;
        end
      end else if ($urandom_range(2, 0) == 0) begin
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(30, 0) == 0) begin
        if_kill = 1;
      end
      if (dc_req) begin
        if (dc_valid && $urandom_range(1, 0) == 0) dc_req = 0;
      end else if ($urandom_range(2, 0) == 0) begin
        dc_req = 1; dc_we = $urandom_range(1, 0) == 1;
        dc_addr = $urandom; dc_wdata = $urandom; dc_be = BE_W'($urandom);
      end
      mem_ack = mem_req ? ($urandom_range(2, 0) == 0) : ($urandom_range(7, 0) == 0);
      mem_rdata = $urandom;
      if ($urandom_range(599, 0) == 0) async_reset_now();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
